// File: rtl/mcp3_prienc008x3.sv
// Combinational 8->3 highest-set-bit encoder with an any-set flag.
// When no bit is set the index reads 0 and any is low.
module mcp3_prienc008x3 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/mcp3_rr_encoder008x3.sv
// 8-way request arbiter/encoder: round-robin or fixed-priority winner,
// registered as a 3-bit index plus one-hot under a valid/ready handshake.
module mcp3_rr_encoder008x3 #(
    parameter bit FIXED_PRI = 1'b0,
    parameter int RESET_PTR = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] req,
    output logic       grant_valid,
    input  logic       grant_ready,
    output logic [2:0] grant_idx,
    output logic [7:0] grant_onehot,
    output logic [7:0] req_ack,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [2:0] RESET_PTR_L = 3'(RESET_PTR);

    state_t      state;
    logic [2:0]  ptr;
    logic [15:0] doubled;
    logic [7:0]  rotated;
    logic [7:0]  lowest;
    logic [7:0]  reversed;
    logic [2:0]  rr_enc;
    logic        rr_any;
    logic [2:0]  rr_idx;
    logic [2:0]  fix_idx;
    logic        fix_any;
    logic [2:0]  win_idx;
    logic        req_any;
    logic        handshake;

    // Rotate so the pointer position lands at bit 0, then isolate the first
    // requester at or after the pointer.
    assign doubled = {req, req} >> ptr;
    assign rotated = doubled[7:0];
    assign lowest  = rotated & (~rotated + 8'd1);

    always_comb begin
        reversed = 8'd0;
        for (int i = 0; i < 8; i++) begin
            reversed[i] = lowest[7-i];
        end
    end

    mcp3_prienc008x3 u_rr_enc (
        .vec (reversed),
        .idx (rr_enc),
        .any (rr_any)
    );

    mcp3_prienc008x3 u_fix_enc (
        .vec (req),
        .idx (fix_idx),
        .any (fix_any)
    );

    // Bit-reversal turned the lowest-bit position k into 7-k; undo and re-offset.
    assign rr_idx  = ptr + (3'd7 - rr_enc);
    assign win_idx = FIXED_PRI ? fix_idx : rr_idx;
    assign req_any = FIXED_PRI ? fix_any : rr_any;

    assign handshake = (state == GRANT) && grant_ready;

    // Winner is sampled only in IDLE and then frozen until the consumer
    // accepts it; the pointer only advances past an accepted grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= RESET_PTR_L;
            grant_idx    <= 3'd0;
            grant_onehot <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state        <= GRANT;
                        grant_idx    <= win_idx;
                        grant_onehot <= 8'd1 << win_idx;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        state <= IDLE;
                        ptr   <= grant_idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_valid = (state == GRANT);
    assign busy        = (state == GRANT);
    assign req_ack     = grant_onehot & {8{handshake}};

endmodule
